// File: rtl/multi_strip_controller.sv
// Multi-strip serial LED driver: per-strip GRB frame buffer, all strips shifted out in lockstep as pulse-width coded bits.
// Define STRIP_DOUBLE_BUFFER_EN for a front/back buffer pair so writes are accepted while a frame is in flight.

module multi_strip_controller #(
    parameter int NUM_LEDS   = 8,
    parameter int NUM_STRIPS = 4,
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int TBIT       = 63,
    parameter int TLATCH     = 3000,
    localparam int SW        = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1,
    localparam int AW        = $clog2(NUM_LEDS * 3)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic [SW-1:0]         write_strip,
    input  logic [AW-1:0]         write_addr,
    input  logic [7:0]            write_data,
    input  logic                  flush,
    output logic                  flushing,
    output logic [NUM_STRIPS-1:0] data_out,
    output logic                  write_err
);

    // state | meaning
    // IDLE  | lines low, waiting for flush
    // SEND  | all strips shifting bits out in lockstep, byte 0 MSB first
    // LATCH | lines held low for TLATCH cycles so the strips latch the frame

    localparam int NBYTES = NUM_LEDS * 3;
    localparam int TMAX   = (TBIT > TLATCH) ? TBIT : TLATCH;
    localparam int TW     = $clog2(TMAX);

    localparam logic [TW-1:0] BIT_LOAD   = TW'(TBIT - 1);
    localparam logic [TW-1:0] LATCH_LOAD = TW'(TLATCH - 1);
    localparam logic [TW-1:0] HI0_FROM   = TW'(TBIT - T0H);
    localparam logic [TW-1:0] HI1_FROM   = TW'(TBIT - T1H);
    localparam logic [AW-1:0] LAST_BYTE  = AW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_LATCH
    } state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         tmr, tmr_nxt;
    logic [2:0]            bit_idx, bit_nxt;
    logic [AW-1:0]         byte_idx, byte_nxt;
    logic                  addr_ok, strip_ok, wr_ok, start;
    logic [NUM_STRIPS-1:0] line_nxt;

    assign addr_ok  = int'(write_addr) < NBYTES;
    assign strip_ok = int'(write_strip) < NUM_STRIPS;
    assign start    = (state == ST_IDLE) && flush;

`ifdef STRIP_DOUBLE_BUFFER_EN
    assign wr_ok = write_en && addr_ok && strip_ok;
`else
    assign wr_ok = write_en && addr_ok && strip_ok && !flushing;
`endif

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SEND;
                    tmr_nxt   = BIT_LOAD;
                    bit_nxt   = 3'd7;
                    byte_nxt  = '0;
                end
            end
            ST_SEND: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - TW'(1);
                end else begin
                    tmr_nxt = BIT_LOAD;
                    // bit index wraps 0 -> 7 as the next byte begins
                    bit_nxt = bit_idx - 3'd1;
                    if (bit_idx == 3'd0) begin
                        if (byte_idx == LAST_BYTE) begin
                            state_nxt = ST_LATCH;
                            tmr_nxt   = LATCH_LOAD;
                            byte_nxt  = '0;
                        end else begin
                            byte_nxt = byte_idx + AW'(1);
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - TW'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            flushing  <= 1'b0;
            data_out  <= '0;
            write_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            bit_idx   <= bit_nxt;
            byte_idx  <= byte_nxt;
            flushing  <= (state_nxt != ST_IDLE);
            data_out  <= (state_nxt == ST_SEND) ? line_nxt : '0;
            write_err <= write_en && !wr_ok;
        end
    end

    for (genvar g = 0; g < NUM_STRIPS; g++) begin : g_strip
        logic [7:0] back_mem [NBYTES];
        logic       hit;
        logic [7:0] rd_byte;
        logic       cur_bit;

        assign hit = wr_ok && (write_strip == SW'(g));

        always_ff @(posedge clk) begin
            if (hit) begin
                back_mem[write_addr] <= write_data;
            end
        end

`ifdef STRIP_DOUBLE_BUFFER_EN
        logic [7:0] front_mem [NBYTES];

        always_ff @(posedge clk) begin
            if (start) begin
                for (int b = 0; b < NBYTES; b++) begin
                    front_mem[b] <= (hit && write_addr == AW'(b)) ? write_data : back_mem[b];
                end
            end
        end

        // the front copy lands on the SEND entry edge, so the first bit is read from the back buffer
        assign rd_byte = start ? ((hit && write_addr == byte_nxt) ? write_data : back_mem[byte_nxt])
                               : front_mem[byte_nxt];
`else
        assign rd_byte = (hit && write_addr == byte_nxt) ? write_data : back_mem[byte_nxt];
`endif

        assign cur_bit     = rd_byte[bit_nxt];
        assign line_nxt[g] = (tmr_nxt >= (cur_bit ? HI1_FROM : HI0_FROM));
    end

endmodule
